// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/sequencing controller.
package pipeline_pkg;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-information and stall/flush/forward bundle between the pipeline stages (master)
// and pipeline_ctrl (slave). All signals are level-sampled once per clock; there is no handshake.
interface pipeline_ctrl_if;
  import pipeline_pkg::*;

  logic [4:0] fetch_rs1;
  logic [4:0] fetch_rs2;
  logic [4:0] decode_rs1;
  logic [4:0] decode_rs2;
  logic [4:0] decode_rd;
  logic [1:0] decode_result_src;
  logic       decode_jump;
  logic       execute_pc_src;
  logic [4:0] mem_rd;
  logic [4:0] wb_rd;
  logic       mem_regfile_wr_enable;
  logic       wb_regfile_wr_enable;
  logic       mem_req;
  logic       mem_ready;

  logic       stall_fetch;
  logic       stall_decode;
  logic       stall_execute;
  logic       stall_mem;
  logic       flush_decode;
  logic       flush_execute;
  logic       flush_wb;
  logic       redirect_en;
  fwd_sel_t   fwd_a;
  fwd_sel_t   fwd_b;
  logic       mem_error;

  modport master (
    output fetch_rs1, fetch_rs2, decode_rs1, decode_rs2, decode_rd, decode_result_src,
           decode_jump, execute_pc_src, mem_rd, wb_rd, mem_regfile_wr_enable,
           wb_regfile_wr_enable, mem_req, mem_ready,
    input  stall_fetch, stall_decode, stall_execute, stall_mem, flush_decode,
           flush_execute, flush_wb, redirect_en, fwd_a, fwd_b, mem_error
  );

  modport slave (
    input  fetch_rs1, fetch_rs2, decode_rs1, decode_rs2, decode_rd, decode_result_src,
           decode_jump, execute_pc_src, mem_rd, wb_rd, mem_regfile_wr_enable,
           wb_regfile_wr_enable, mem_req, mem_ready,
    output stall_fetch, stall_decode, stall_execute, stall_mem, flush_decode,
           flush_execute, flush_wb, redirect_en, fwd_a, fwd_b, mem_error
  );
endinterface

// File: rtl/pipeline_ctrl_forward_sel.sv
// Execute-operand forwarding select for one source register; memory stage wins over writeback.
module forward_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_wr_enable,
  input  logic       wb_wr_enable,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_NONE;
    if (mem_wr_enable && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wr_enable && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward controller with a data-memory wait FSM and watchdog release.
// Optional performance counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.slave    bus,
  output ctrl_state_t       state
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_count
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrl_state_t state_q;
  ctrl_state_t next_state;
  logic [7:0]  wait_cnt;
  logic        mem_error_q;
  logic        mem_stall;
  logic        timeout_hit;
  logic        load_use;
  logic        redirect;
  fwd_sel_t    sel_a;
  fwd_sel_t    sel_b;

  forward_sel u_fwd_a (
    .rs            (bus.decode_rs1),
    .mem_rd        (bus.mem_rd),
    .wb_rd         (bus.wb_rd),
    .mem_wr_enable (bus.mem_regfile_wr_enable),
    .wb_wr_enable  (bus.wb_regfile_wr_enable),
    .sel           (sel_a)
  );

  forward_sel u_fwd_b (
    .rs            (bus.decode_rs2),
    .mem_rd        (bus.mem_rd),
    .wb_rd         (bus.wb_rd),
    .mem_wr_enable (bus.mem_regfile_wr_enable),
    .wb_wr_enable  (bus.wb_regfile_wr_enable),
    .sel           (sel_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt    <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q <= next_state;
      // Counter restarts on entry so wait_cnt == N means N+1 cycles already stalled.
      if (state_q == RUN) begin
        wait_cnt <= 8'd0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) begin
        mem_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state        = state_q;
    timeout_hit       = 1'b0;
    mem_stall         = 1'b0;
    load_use          = 1'b0;
    redirect          = 1'b0;
    bus.stall_fetch   = 1'b0;
    bus.stall_decode  = 1'b0;
    bus.stall_execute = 1'b0;
    bus.stall_mem     = 1'b0;
    bus.flush_decode  = 1'b0;
    bus.flush_execute = 1'b0;
    bus.flush_wb      = 1'b0;
    bus.redirect_en   = 1'b0;
    bus.fwd_a         = FWD_NONE;
    bus.fwd_b         = FWD_NONE;

    case (state_q)
      RUN: begin
        mem_stall = bus.mem_req && !bus.mem_ready;
        if (mem_stall) next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        timeout_hit = !bus.mem_ready && (wait_cnt == WAIT_LAST);
        mem_stall   = !bus.mem_ready && !timeout_hit;
        if (!mem_stall) next_state = RUN;
      end
      default: next_state = RUN;
    endcase

    load_use = (bus.decode_result_src == RESULT_SRC_MEM) && (bus.decode_rd != 5'd0) &&
               ((bus.decode_rd == bus.fetch_rs1) || (bus.decode_rd == bus.fetch_rs2));
    redirect = bus.execute_pc_src || bus.decode_jump;

    if (rst) begin
      bus.flush_decode  = 1'b1;
      bus.flush_execute = 1'b1;
      bus.flush_wb      = 1'b1;
    end else begin
      bus.fwd_a = sel_a;
      bus.fwd_b = sel_b;
      if (mem_stall) begin
        // Branches stay frozen in execute and are re-presented after release.
        bus.stall_fetch   = 1'b1;
        bus.stall_decode  = 1'b1;
        bus.stall_execute = 1'b1;
        bus.stall_mem     = 1'b1;
        bus.flush_wb      = 1'b1;
      end else if (timeout_hit) begin
        bus.flush_wb = 1'b1;
      end else if (redirect) begin
        bus.redirect_en   = 1'b1;
        bus.flush_decode  = 1'b1;
        bus.flush_execute = 1'b1;
      end else if (load_use) begin
        bus.stall_fetch   = 1'b1;
        bus.stall_decode  = 1'b1;
        bus.flush_execute = 1'b1;
      end
    end
  end

  assign bus.mem_error = mem_error_q;
  assign state         = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_count  <= 32'd0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + {31'd0, bus.stall_fetch};
      perf_flush_count  <= perf_flush_count + {31'd0, bus.redirect_en};
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: driver pushes expected outputs, a negedge monitor checks.
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  localparam int W = 14;

  typedef struct packed {
    logic       rst;
    logic [4:0] fetch_rs1;
    logic [4:0] fetch_rs2;
    logic [4:0] decode_rs1;
    logic [4:0] decode_rs2;
    logic [4:0] decode_rd;
    logic [1:0] decode_result_src;
    logic       decode_jump;
    logic       execute_pc_src;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_en;
    logic       wb_en;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  localparam logic [3:0] S_NO  = 4'b0000;
  localparam logic [3:0] S_ALL = 4'b1111;
  localparam logic [3:0] S_FD  = 4'b1100;
  localparam logic [2:0] F_NO  = 3'b000;
  localparam logic [2:0] F_RST = 3'b111;
  localparam logic [2:0] F_WB  = 3'b001;
  localparam logic [2:0] F_RED = 3'b110;
  localparam logic [2:0] F_EX  = 3'b010;
  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] WB    = 2'b01;
  localparam logic [1:0] MEM   = 2'b10;

  logic        clk;
  logic        rst;
  ctrl_state_t state;
  stim_t       stim;
  int          tests_run;
  int          tests_failed;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  pipeline_ctrl_if bus ();

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
  logic        perf_check;
  logic [63:0] perf_exp;
  logic        perf_chk_q[$];
  logic [63:0] perf_exp_q[$];
`endif

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ev(input logic [3:0] stalls, input logic [2:0] flushes,
                                      input logic re, input logic [1:0] fa, input logic [1:0] fb,
                                      input logic err, input logic st);
    return {stalls, flushes, re, fa, fb, err, st};
  endfunction

  task automatic apply();
    rst                       = stim.rst;
    bus.fetch_rs1             = stim.fetch_rs1;
    bus.fetch_rs2             = stim.fetch_rs2;
    bus.decode_rs1            = stim.decode_rs1;
    bus.decode_rs2            = stim.decode_rs2;
    bus.decode_rd             = stim.decode_rd;
    bus.decode_result_src     = stim.decode_result_src;
    bus.decode_jump           = stim.decode_jump;
    bus.execute_pc_src        = stim.execute_pc_src;
    bus.mem_rd                = stim.mem_rd;
    bus.wb_rd                 = stim.wb_rd;
    bus.mem_regfile_wr_enable = stim.mem_en;
    bus.wb_regfile_wr_enable  = stim.wb_en;
    bus.mem_req               = stim.mem_req;
    bus.mem_ready             = stim.mem_ready;
  endtask

  // Driver: one vector per clock, expected response queued at issue time.
  task automatic step(input string name, input logic [W-1:0] exp);
    @(posedge clk);
    #1;
    apply();
    exp_q.push_back(exp);
    name_q.push_back(name);
`ifdef PIPELINE_CTRL_PERF_EN
    perf_chk_q.push_back(perf_check);
    perf_exp_q.push_back(perf_exp);
    perf_check = 1'b0;
`endif
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        act = {bus.stall_fetch, bus.stall_decode, bus.stall_execute, bus.stall_mem,
               bus.flush_decode, bus.flush_execute, bus.flush_wb, bus.redirect_en,
               bus.fwd_a, bus.fwd_b, bus.mem_error, (state == MEM_WAIT)};
        tests_run++;
        if (act !== e) begin
          tests_failed++;
          $display("FAIL %s: got %b expected %b (sf sd se sm fd fe fw re fa fb err st)", n, act, e);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        if (perf_chk_q.pop_front()) begin
          e = '0;
          tests_run++;
          if ({perf_stall_cycles, perf_flush_count} !== perf_exp_q.pop_front()) begin
            tests_failed++;
            $display("FAIL %s_perf: got stall=%0d flush=%0d expected 0/0", n,
                     perf_stall_cycles, perf_flush_count);
          end
        end else begin
          void'(perf_exp_q.pop_front());
        end
`endif
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef PIPELINE_CTRL_PERF_EN
    perf_check = 1'b0;
    perf_exp   = '0;
`endif
    stim     = '0;
    stim.rst = 1'b1;
    apply();

    step("reset", ev(S_NO, F_RST, 0, NONE, NONE, 0, 0));
    stim.rst = 1'b0;
    step("idle", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));

    // Load-use
    stim.decode_result_src = RESULT_SRC_MEM; stim.decode_rd = 5'd5; stim.fetch_rs1 = 5'd5;
    step("load_use_rs1", ev(S_FD, F_EX, 0, NONE, NONE, 0, 0));
    stim.decode_result_src = 2'b00; stim.decode_rd = 5'd0;
    step("after_bubble", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));
    stim.decode_result_src = RESULT_SRC_MEM; stim.fetch_rs1 = 5'd0;
    step("load_use_x0", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));
    stim.decode_rd = 5'd9; stim.fetch_rs2 = 5'd9;
    step("load_use_rs2", ev(S_FD, F_EX, 0, NONE, NONE, 0, 0));
    stim.execute_pc_src = 1'b1;
    step("redirect_over_lu", ev(S_NO, F_RED, 1, NONE, NONE, 0, 0));
    stim = '0; stim.decode_jump = 1'b1;
    step("jump", ev(S_NO, F_RED, 1, NONE, NONE, 0, 0));

    // Memory wait, ready after 3 cycles
    stim = '0; stim.mem_req = 1'b1;
    step("wait3_c1", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 0));
    step("wait3_c2", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 1));
    step("wait3_c3", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 1));
    stim.mem_ready = 1'b1;
    step("wait3_ready", ev(S_NO, F_NO, 0, NONE, NONE, 0, 1));
    stim = '0;
    step("wait3_after", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));

    // Branch held during wait
    stim.mem_req = 1'b1; stim.execute_pc_src = 1'b1;
    step("br_wait_c1", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 0));
    step("br_wait_c2", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 1));
    stim.mem_ready = 1'b1;
    step("br_release", ev(S_NO, F_RED, 1, NONE, NONE, 0, 1));
    stim = '0;
    step("br_after", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));

    // Forwarding
    stim.mem_rd = 5'd7; stim.wb_rd = 5'd7; stim.mem_en = 1'b1; stim.wb_en = 1'b1;
    stim.decode_rs1 = 5'd7;
    step("fwd_mem_prio", ev(S_NO, F_NO, 0, MEM, NONE, 0, 0));
    stim.mem_en = 1'b0;
    step("fwd_wb", ev(S_NO, F_NO, 0, WB, NONE, 0, 0));
    stim.mem_rd = 5'd0; stim.wb_rd = 5'd0; stim.mem_en = 1'b1; stim.decode_rs1 = 5'd0;
    step("fwd_x0", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));
    stim.mem_rd = 5'd3; stim.wb_rd = 5'd4; stim.decode_rs1 = 5'd4; stim.decode_rs2 = 5'd3;
    step("fwd_split", ev(S_NO, F_NO, 0, WB, MEM, 0, 0));
    stim.mem_en = 1'b0;
    step("fwd_mem_off", ev(S_NO, F_NO, 0, WB, NONE, 0, 0));

    // Watchdog timeout (MEM_TIMEOUT = 4)
    stim = '0; stim.mem_req = 1'b1;
    step("to_c1", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 0));
    step("to_c2", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 1));
    step("to_c3", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 1));
    step("to_c4", ev(S_ALL, F_WB, 0, NONE, NONE, 0, 1));
    step("to_release", ev(S_NO, F_WB, 0, NONE, NONE, 0, 1));
    stim = '0;
    step("to_error_set", ev(S_NO, F_NO, 0, NONE, NONE, 1, 0));
    step("to_error_sticky", ev(S_NO, F_NO, 0, NONE, NONE, 1, 0));

    // Reset during the 2nd wait cycle
    stim.mem_req = 1'b1;
    step("rst_wait_c1", ev(S_ALL, F_WB, 0, NONE, NONE, 1, 0));
    stim.rst = 1'b1;
    step("rst_in_wait", ev(S_NO, F_RST, 0, NONE, NONE, 1, 1));
    stim = '0;
`ifdef PIPELINE_CTRL_PERF_EN
    perf_check = 1'b1;
    perf_exp   = '0;
`endif
    step("rst_after", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));

    // Zero-latency access
    stim.mem_req = 1'b1; stim.mem_ready = 1'b1;
    step("mem_k0", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));
    stim = '0;
    step("mem_k0_after", ev(S_NO, F_NO, 0, NONE, NONE, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
